pipeline_hazard_ctrl: RTL

// Sequences the four inter-stage buffers (IF_ID, ID_EXE, EXE_MEM, MEM_WB) and the PC register.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 41 ++++
 rtl/pipeline_hazard_ctrl_if.sv | 45 ++++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding,
// default register-number width and the go/clear control bundle.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned REG_W_DEF = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALTED   = 2'd2
    } state_t;

    // Bit order fixes the bundle positions, MSB first.
    typedef struct packed {
        logic pc_go;
        logic if_id_go;
        logic if_id_clear;
        logic id_exe_go;
        logic id_exe_clear;
        logic exe_mem_go;
        logic exe_mem_clear;
        logic mem_wb_go;
        logic mem_wb_clear;
    } ctrl_t;

    // Same go/clear pair applied to every buffer (PC has no clear).
    function automatic ctrl_t ctrl_uniform(input logic go, input logic clear);
        ctrl_t c;
        c.pc_go         = go;
        c.if_id_go      = go;
        c.if_id_clear   = clear;
        c.id_exe_go     = go;
        c.id_exe_clear  = clear;
        c.exe_mem_go    = go;
        c.exe_mem_clear = clear;
        c.mem_wb_go     = go;
        c.mem_wb_clear  = clear;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle: hazard sources from the
// pipeline stages and go/clear enables back to the buffers and PC.
interface pipeline_hazard_ctrl_if
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = REG_W_DEF
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_wreg;
    logic             branch_taken;
    logic             mem_busy;
    logic             halt_req;
    logic             resume;

    logic pc_go;
    logic if_id_go;
    logic if_id_clear;
    logic id_exe_go;
    logic id_exe_clear;
    logic exe_mem_go;
    logic exe_mem_clear;
    logic mem_wb_go;
    logic mem_wb_clear;

    // Datapath side
    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_wreg,
               branch_taken, mem_busy, halt_req, resume,
        input  pc_go, if_id_go, if_id_clear, id_exe_go, id_exe_clear,
               exe_mem_go, exe_mem_clear, mem_wb_go, mem_wb_clear
    );

    // Controller side
    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_wreg,
               branch_taken, mem_busy, halt_req, resume,
        output pc_go, if_id_go, if_id_clear, id_exe_go, id_exe_clear,
               exe_mem_go, exe_mem_clear, mem_wb_go, mem_wb_clear
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare: the load in EX writes a register that the
// instruction in ID reads. Register 0 never creates a dependency.
module pipeline_hazard_ctrl_hazard_detect #(
    parameter int unsigned REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_wreg,
    output logic             load_use_c
);

    logic rs_hit_c;
    logic rt_hit_c;

    assign rs_hit_c   = id_uses_rs && (id_rs == ex_wreg);
    assign rt_hit_c   = id_uses_rt && (id_rt == ex_wreg);
    assign load_use_c = ex_mem_read && (ex_wreg != '0) && (rs_hit_c || rt_hit_c);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/freeze/halt sequencing of the PC and
// inter-stage buffers. Performance counters exist only with PIPE_PERF_CNT_EN.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_W       = REG_W_DEF,
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipeline_hazard_ctrl_if.slave pif,
    output logic                 halted,
    output logic                 mem_err,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_count
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state_q;
    state_t            state_d;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic              mem_err_d;
    logic              run_rules_c;
    logic              load_use_c;
    ctrl_t             ctrl_c;
    ctrl_t             ctrl_gated_c;

    pipeline_hazard_ctrl_hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard_detect (
        .id_rs       (pif.id_rs),
        .id_rt       (pif.id_rt),
        .id_uses_rs  (pif.id_uses_rs),
        .id_uses_rt  (pif.id_uses_rt),
        .ex_mem_read (pif.ex_mem_read),
        .ex_wreg     (pif.ex_wreg),
        .load_use_c  (load_use_c)
    );

    // State, wait counter and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
            mem_err <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            mem_err <= mem_err_d;
        end
    end

    // Next state and go/clear decode; leaving MEM_WAIT re-runs the branch/load rules
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        mem_err_d   = mem_err;
        run_rules_c = 1'b0;
        ctrl_c      = ctrl_uniform(1'b0, 1'b0);

        case (state_q)
            ST_RUN: begin
                if (pif.halt_req) begin
                    state_d = ST_HALTED;
                end else if (pif.mem_busy) begin
                    state_d = ST_MEM_WAIT;
                    wait_d  = WAIT_W'(1);
                end else begin
                    run_rules_c = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (pif.mem_busy) begin
                    if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
                        mem_err_d = 1'b1;
                        state_d   = ST_HALTED;
                        wait_d    = '0;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end else begin
                    state_d     = ST_RUN;
                    wait_d      = '0;
                    run_rules_c = 1'b1;
                end
            end
            ST_HALTED: begin
                if (pif.resume) begin
                    state_d   = ST_RUN;
                    mem_err_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_RUN;
                wait_d  = '0;
            end
        endcase

        if (run_rules_c) begin
            ctrl_c = ctrl_uniform(1'b1, 1'b0);
            if (pif.branch_taken) begin
                // ID holds a wrong-path instruction, so a load-use there is moot
                ctrl_c.if_id_clear  = 1'b1;
                ctrl_c.id_exe_clear = 1'b1;
            end else if (load_use_c) begin
                ctrl_c.pc_go        = 1'b0;
                ctrl_c.if_id_go     = 1'b0;
                ctrl_c.id_exe_clear = 1'b1;
            end
        end
    end

    // Enables are held inactive for as long as reset is asserted
    assign ctrl_gated_c = rst_n ? ctrl_c : ctrl_uniform(1'b0, 1'b0);

    assign pif.pc_go         = ctrl_gated_c.pc_go;
    assign pif.if_id_go      = ctrl_gated_c.if_id_go;
    assign pif.if_id_clear   = ctrl_gated_c.if_id_clear;
    assign pif.id_exe_go     = ctrl_gated_c.id_exe_go;
    assign pif.id_exe_clear  = ctrl_gated_c.id_exe_clear;
    assign pif.exe_mem_go    = ctrl_gated_c.exe_mem_go;
    assign pif.exe_mem_clear = ctrl_gated_c.exe_mem_clear;
    assign pif.mem_wb_go     = ctrl_gated_c.mem_wb_go;
    assign pif.mem_wb_clear  = ctrl_gated_c.mem_wb_clear;

    assign halted = (state_q == ST_HALTED);

`ifdef PIPE_PERF_CNT_EN
    logic stall_inc_c;
    logic flush_inc_c;

    // Memory-freeze cycles (including the entry cycle) plus load-use bubbles
    assign stall_inc_c = ((state_q == ST_RUN) && !pif.halt_req && pif.mem_busy) ||
                         ((state_q == ST_MEM_WAIT) && pif.mem_busy) ||
                         (run_rules_c && !pif.branch_taken && load_use_c);
    assign flush_inc_c = run_rules_c && pif.branch_taken;

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_inc_c && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (flush_inc_c && (flush_count != {CNT_W{1'b1}})) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
